// File: rtl/sig_delay_pkg.sv
// Shared types and helpers for the sig_delay_line audio delay block.
// Holds the run-time mode encoding and the saturating adder used by the echo path.
package sig_delay_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_DELAY  = 2'd1,
    MODE_ECHO   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // Operands arrive sign-extended from a w-bit sample, so 32 bits never overflows.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi)
      return hi;
    else if (sum < lo)
      return lo;
    else
      return sum;
  endfunction

endpackage

// File: rtl/sig_delay_line_if.sv
// Sample stream interface between the mic/ADC source, the delay line and the output stage.
interface sig_delay_line_if #(parameter int DATA_W = 8);

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;
  logic                     fill_done;

  modport master (
    output in_valid, in_sample,
    input  out_valid, out_sample, fill_done
  );

  modport slave (
    input  in_valid, in_sample,
    output out_valid, out_sample, fill_done
  );

endinterface

// File: rtl/sig_delay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no reset.
// Same-address read-during-write is undefined, so callers must forward that case themselves.
module sig_delay_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sig_delay_line.sv
// Circular-buffer delay line with bypass, pure-delay and saturated echo modes.
// Stage 1 captures the sample and its controls alongside the RAM read; stage 2 forms the output.
module sig_delay_line
  import sig_delay_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  delay,
  input  logic [SHIFT_W-1:0] gain_shift,
  sig_delay_line_if.slave    bus
);

  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  logic                     accept;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        fill_cnt;
  logic [DATA_W-1:0]        ram_rdata;

  logic                     s1_valid;
  mode_t                    s1_mode;
  logic [SHIFT_W-1:0]       s1_shift;
  logic signed [DATA_W-1:0] s1_sample;
  logic                     s1_fwd;
  logic                     s1_mute;

  logic signed [DATA_W-1:0] d_term;
  logic signed [DATA_W-1:0] d_shifted;
  logic signed [31:0]       echo_sum;
  logic signed [DATA_W-1:0] result;

  assign accept        = en & bus.in_valid;
  assign rd_addr       = wr_ptr - delay;
  assign bus.fill_done = (fill_cnt == FILL_MAX);

  sig_delay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.in_sample),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // D == 0 would be a same-address read-during-write, so the sample is forwarded instead;
  // delays reaching past what has been written since reset read as silence.
  always_comb begin
    d_term    = '0;
    d_shifted = '0;
    echo_sum  = '0;
    result    = s1_sample;
    if (s1_fwd)
      d_term = s1_sample;
    else if (!s1_mute)
      d_term = $signed(ram_rdata);
    d_shifted = d_term >>> s1_shift;
    echo_sum  = sat_add(32'(s1_sample), 32'(d_shifted), DATA_W);
    case (s1_mode)
      MODE_DELAY: result = d_term;
      MODE_ECHO:  result = echo_sum[DATA_W-1:0];
      default:    result = s1_sample;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      s1_valid       <= 1'b0;
      s1_mode        <= MODE_BYPASS;
      s1_shift       <= '0;
      s1_sample      <= '0;
      s1_fwd         <= 1'b0;
      s1_mute        <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_sample <= '0;
    end else begin
      s1_valid      <= accept;
      bus.out_valid <= s1_valid;
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        if (fill_cnt != FILL_MAX)
          fill_cnt <= fill_cnt + 1'b1;
        s1_mode   <= mode_t'(mode);
        s1_shift  <= gain_shift;
        s1_sample <= bus.in_sample;
        s1_fwd    <= (delay == '0);
        s1_mute   <= (delay > fill_cnt);
      end
      if (s1_valid)
        bus.out_sample <= result;
    end
  end

endmodule

// File: tb/tb_sig_delay_line.sv
// Self-checking bench for sig_delay_line: directed scenarios plus a randomized run,
// all scored against a sample-history model of the delay line.
module tb_sig_delay_line;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int SHIFT_W = 3;
  localparam int DEPTH   = 2**ADDR_W;

  typedef struct {
    int due;
    int val;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [ADDR_W-1:0]  delay = '0;
  logic [SHIFT_W-1:0] gain_shift = '0;

  sig_delay_line_if #(.DATA_W(DATA_W)) bus ();

  sig_delay_line #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .delay      (delay),
    .gain_shift (gain_shift),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   cycle      = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  int   hist[$];
  exp_t expQ[$];
  int   lastOut    = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    #1;
  endtask

  // Reference: output is a function of the samples written since reset, nothing else.
  function automatic int modelOut(input int m, input int d, input int sh, input int x);
    int dterm;
    int e;
    if (d == 0)
      dterm = x;
    else if (d > hist.size())
      dterm = 0;
    else
      dterm = hist[hist.size() - d];
    case (m)
      1: return dterm;
      2: begin
        e = x + (dterm >>> sh);
        if (e > 127) e = 127;
        if (e < -128) e = -128;
        return e;
      end
      default: return x;
    endcase
  endfunction

  task automatic applyStimulus(input bit v, input int x);
    bit acc;
    bus.in_valid  = v;
    bus.in_sample = DATA_W'(x);
    acc = v && en;
    if (acc)
      expQ.push_back('{due: cycle + 2, val: modelOut(int'(mode), int'(delay), int'(gain_shift), x)});
    tick();
    if (acc)
      hist.push_back(x);
    bus.in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    hist.delete();
    expQ.delete();
    lastOut = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Checks every cycle: strobe timing, held value between pulses and fill status.
  always @(negedge clk) begin
    bit expValid;
    expValid = (expQ.size() > 0) && (expQ[0].due == cycle);
    if (bus.out_valid || expValid)
      checkOutput("out_valid", int'(bus.out_valid), int'(expValid));
    if (expValid) begin
      lastOut = expQ[0].val;
      void'(expQ.pop_front());
    end
    checkOutput("out_sample", int'(bus.out_sample), lastOut);
    checkOutput("fill_done", int'(bus.fill_done), int'(hist.size() >= DEPTH - 1));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    tick();
    checkOutput("reset_valid", int'(bus.out_valid), 0);
    checkOutput("reset_sample", int'(bus.out_sample), 0);
    rst = 1'b1;
    tick();
    en = 1'b1;

    // Pure delay of 4 on a back-to-back ramp
    mode = 2'd1; delay = 4;
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, i);
    tick();
    checkOutput("delay4_last", int'(bus.out_sample), 6);

    // Echo saturation at both rails
    doReset();
    mode = 2'd2; delay = 1; gain_shift = 0;
    applyStimulus(1'b1, 100);
    applyStimulus(1'b1, 100);
    tick();
    checkOutput("sat_hi", int'(bus.out_sample), 127);
    applyStimulus(1'b1, -100);
    applyStimulus(1'b1, -100);
    tick();
    checkOutput("sat_lo", int'(bus.out_sample), -128);

    // Echo attenuation
    doReset();
    delay = 2; gain_shift = 2;
    applyStimulus(1'b1, 40);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);
    tick();
    checkOutput("atten", int'(bus.out_sample), 10);

    // Wrap-around at the maximum delay and fill_done rising
    doReset();
    mode = 2'd1; delay = DEPTH - 1; gain_shift = 0;
    for (int n = 0; n <= 40; n++) begin
      applyStimulus(1'b1, n);
      if (n == 13) checkOutput("fill_pre", int'(bus.fill_done), 0);
      if (n == 14) checkOutput("fill_post", int'(bus.fill_done), 1);
    end
    tick();
    checkOutput("wrap_last", int'(bus.out_sample), 25);

    // Forwarding at D=0, then en gating must not advance the write pointer
    delay = 0;
    applyStimulus(1'b1, 55);
    tick();
    checkOutput("fwd", int'(bus.out_sample), 55);
    en = 1'b0;
    applyStimulus(1'b1, 99);
    applyStimulus(1'b1, 98);
    tick();
    checkOutput("gated_hold", int'(bus.out_sample), 55);
    en = 1'b1; delay = 1;
    applyStimulus(1'b1, 56);
    tick();
    checkOutput("gated_resume", int'(bus.out_sample), 55);

    // Reset mid-stream restarts the fill
    doReset();
    delay = 3;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, int'($urandom_range(0, 255)) - 128);
    doReset();
    for (int i = 7; i <= 10; i++) applyStimulus(1'b1, i);
    tick();
    checkOutput("reset_restart", int'(bus.out_sample), 7);

    // Randomized mix of modes, delays, gaps and enable drops
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      mode       = 2'($urandom_range(0, 3));
      delay      = ADDR_W'($urandom_range(0, DEPTH - 1));
      gain_shift = SHIFT_W'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128);
      if (i == 300) doReset();
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("drain", expQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sig_delay_line.md
Name: sig_delay_line

Overview:
- Parametrised successor to the single-tap microphone delay path.
- Circular-buffer delay line for signed audio samples with a programmable delay in samples, measured from each sample's arrival.
- Three run-time modes: bypass, pure delay, and echo (dry + attenuated delayed sample, saturated).
- Sits between the ADC/mic sample source and the DAC/output stage; driven by a per-sample valid strobe rather than free-running every clock.

Parameters:
- DATA_W, 8, sample width in bits (two's complement).
- ADDR_W, 9, buffer address width; depth = 2**ADDR_W samples.
- SHIFT_W, 3, width of echo attenuation shift control.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  block enable; when 0, in_valid is ignored and no state advances.
- mode  input  2  0 bypass, 1 delay, 2 echo, 3 reserved (behaves as bypass).
- delay  input  ADDR_W  delay D in samples, 0..2**ADDR_W-1; sampled on each accepted sample.
- gain_shift  input  SHIFT_W  echo attenuation: delayed term is arithmetically shifted right by this amount.
- in_valid  input  1  sample strobe, one cycle per sample.
- in_sample  input  DATA_W  signed input sample.
- out_valid  output  1  result strobe.
- out_sample  output  DATA_W  signed output sample.
- fill_done  output  1  high once the buffer holds at least 2**ADDR_W-1 samples written since reset.

Behaviour:
- Accepted sample: in_valid && en at a rising clk edge.
- Reset (rst=0, asynchronous): wr_ptr=0, fill_cnt=0, out_valid=0, out_sample=0, fill_done=0. Buffer contents are not cleared.
- On an accepted sample at edge t:
  - mem[wr_ptr] <= in_sample;
  - rd_addr = wr_ptr - D, modulo 2**ADDR_W;
  - wr_ptr increments and wraps from 2**ADDR_W-1 to 0;
  - fill_cnt increments and saturates at 2**ADDR_W-1.
- Latency: out_valid pulses exactly one cycle after each accepted sample, and only then. out_sample holds its value between pulses.
- Delayed term d:
  - D == 0: d = current in_sample. This is forwarded, not read from RAM; read-during-write must not return stale data.
  - D > fill_cnt (count before this sample): d = 0, muting stale memory after reset.
  - Otherwise: d = mem[rd_addr], read synchronously with a 1-cycle RAM read.
- Output selection (mode, delay, gain_shift and in_sample are registered with the sample so the result is coherent):
  - bypass: out_sample = in_sample.
  - delay: out_sample = d.
  - echo: out_sample = sat(in_sample + (d >>> gain_shift)).
    - The sum is computed at DATA_W+1 bits, then saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
    - gain_shift=0 gives full-scale echo.
- Delay changes take effect on the next accepted sample; no flush occurs. Reducing D yields data immediately if fill_cnt allows.
- en low mid-stream: pointers and fill_cnt freeze; out_valid stays 0; the stream resumes seamlessly when en returns high.
- in_valid on consecutive cycles is supported at full rate, one sample per clock.
- Reset asserted mid-operation: any pending out_valid is dropped; fill restarts, so delayed output is 0 until D samples have been rewritten.

Decomposition:
- Package sig_delay_pkg: enum mode_t {MODE_BYPASS, MODE_DELAY, MODE_ECHO, MODE_RSVD}; a saturation function sat_add.
- Sub-module sig_delay_ram: simple dual-port synchronous RAM, parametrised DATA_W/ADDR_W, one write port and one registered read port. It has no reset, and read-during-write to the same address is undefined, which is why the top level forwards the D == 0 case.
- Top level holds the pointers, fill counter, forwarding mux, echo adder/saturator and output register.

Test Plan:
- Reset, then mode=1, D=4, feed samples 1,2,3,...,10 back-to-back -> outputs 0,0,0,0,1,2,3,4,5,6, each one cycle after its input.
- Echo saturation: mode=2, D=1, gain_shift=0, samples 100,100 (DATA_W=8) -> second output 127; samples -100,-100 -> second output -128.
- Echo attenuation: mode=2, D=2, gain_shift=2, samples 40,0,0 -> outputs 40, 0, 10.
- Wrap-around: ADDR_W=4, D=15, ramp 0..40 -> output n equals n-15 for n≥15 and 0 before; fill_done rises after 15 samples.
- D=0 forwarding and en gating: mode=1, D=0, sample 55 -> output 55 next cycle; en=0 with in_valid=1 -> no out_valid pulse and wr_ptr unchanged.
- Reset mid-stream: after 20 samples at D=3, pulse rst low, resume with 7,8,9,10 -> outputs 0,0,0,7.
